// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package ifetch_pkg;

    // Fetch sequencer states; a dropped transaction reuses WAIT with a flag.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        HOLD = 2'b11
    } state_t;

    // Error codes reported on err_code.
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

endpackage

// File: rtl/ifetch_wait_timer.sv
// Counts cycles spent waiting for read data after a grant.
// expire is raised during the MAX_WAIT-th waiting cycle, i.e. the cycle in
// which the count would step up to MAX_WAIT; read data arriving in that
// same cycle still takes precedence in the parent FSM.
module ifetch_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear dominates, otherwise advance while enabled.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = enable && (count_q == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch reader: accepts a PC, performs one word read from
// instruction memory and holds the result for decode until accepted.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              pc_valid,
    output logic              pc_ready,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              fetch_err,
    output logic [1:0]        err_code
);

    state_t            state_q, state_d;
    logic              drop_q, drop_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              fetch_err_q, fetch_err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              timer_expire;

    ifetch_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state_q != WAIT),
        .enable  (state_q == WAIT),
        .expire  (timer_expire)
    );

    // State and datapath registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            drop_q      <= 1'b0;
            addr_q      <= '0;
            instr_q     <= '0;
            instr_pc_q  <= '0;
            fetch_err_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            drop_q      <= drop_d;
            addr_q      <= addr_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            fetch_err_q <= fetch_err_d;
            err_code_q  <= err_code_d;
        end
    end

    // Next-state logic; flush overrides every other event. A flush that
    // coincides with rvalid in WAIT retires the transaction immediately.
    always_comb begin
        state_d     = state_q;
        drop_d      = drop_q;
        addr_d      = addr_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        fetch_err_d = 1'b0;
        err_code_d  = err_code_q;
        case (state_q)
            IDLE: begin
                if (pc_valid && !flush) begin
                    if (pc_in[1:0] == 2'b00) begin
                        addr_d  = pc_in;
                        state_d = REQ;
                    end else begin
                        fetch_err_d = 1'b1;
                        err_code_d  = ERR_MISALIGN;
                    end
                end
            end
            REQ: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (imem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (drop_q || flush) begin
                        state_d = IDLE;
                        drop_d  = 1'b0;
                    end else begin
                        instr_d    = imem_rdata;
                        instr_pc_d = addr_q;
                        state_d    = HOLD;
                    end
                end else if (timer_expire) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                    if (!drop_q && !flush) begin
                        fetch_err_d = 1'b1;
                        err_code_d  = ERR_TIMEOUT;
                    end
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end
            HOLD: begin
                if (flush || instr_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        pc_ready    = 1'b0;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state_q)
            IDLE:    pc_ready    = !drop_q;
            REQ:     imem_req    = 1'b1;
            HOLD:    instr_valid = 1'b1;
            default: ;
        endcase
    end

    assign imem_addr = addr_q;
    assign instr     = instr_q;
    assign instr_pc  = instr_pc_q;
    assign fetch_err = fetch_err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios with literal
// expectations followed by randomized traffic against a transaction-level model.
module tb_ifetch_unit;

    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] pc_in = '0;
    logic        pc_valid = 1'b0;
    logic        pc_ready;
    logic        flush = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_err;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    // Model: what the unit is doing, expressed as a transaction in flight.
    bit          mReqPending;
    int          mWaitCount;
    bit          mDropping;
    bit          mHolding;
    logic [31:0] mAddr;
    logic [31:0] mInstr;
    logic [31:0] mInstrPc;
    bit          mErr;
    logic [1:0]  mErrCode;
    int          rvTarget = 1;

    ifetch_unit #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pc_in       (pc_in),
        .pc_valid    (pc_valid),
        .pc_ready    (pc_ready),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .fetch_err   (fetch_err),
        .err_code    (err_code)
    );

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    function automatic bit modelIdle();
        return !mReqPending && (mWaitCount < 0) && !mHolding;
    endfunction

    task automatic modelReset();
        mReqPending = 1'b0;
        mWaitCount  = -1;
        mDropping   = 1'b0;
        mHolding    = 1'b0;
        mAddr       = '0;
        mInstr      = '0;
        mInstrPc    = '0;
        mErr        = 1'b0;
        mErrCode    = 2'b00;
    endtask

    // Advances the model by one clock edge given the inputs present at that edge.
    task automatic modelStep(input bit pv, input logic [31:0] pc, input bit fl,
                             input bit gt, input bit rv, input logic [31:0] rd,
                             input bit rdy);
        bit errNext;
        int waited;
        errNext = 1'b0;
        if (modelIdle()) begin
            if (pv && !fl) begin
                if (pc % 4 == 0) begin
                    mReqPending = 1'b1;
                    mAddr = pc;
                end else begin
                    errNext  = 1'b1;
                    mErrCode = 2'b01;
                end
            end
        end else if (mReqPending) begin
            if (fl) begin
                mReqPending = 1'b0;
            end else if (gt) begin
                mReqPending = 1'b0;
                mWaitCount  = 0;
            end
        end else if (mWaitCount >= 0) begin
            waited = mWaitCount + 1;
            if (rv) begin
                if (!mDropping && !fl) begin
                    mHolding = 1'b1;
                    mInstr   = rd;
                    mInstrPc = mAddr;
                end
                mWaitCount = -1;
                mDropping  = 1'b0;
            end else if (waited == MAX_WAIT) begin
                if (!mDropping && !fl) begin
                    errNext  = 1'b1;
                    mErrCode = 2'b10;
                end
                mWaitCount = -1;
                mDropping  = 1'b0;
            end else begin
                mWaitCount = waited;
                if (fl) mDropping = 1'b1;
            end
        end else if (mHolding) begin
            if (fl || rdy) mHolding = 1'b0;
        end
        mErr = errNext;
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compares every DUT output with the model once per cycle.
    task automatic checkOutput();
        checkVal("pc_ready", 32'(pc_ready), 32'(modelIdle() && !mDropping));
        checkVal("imem_req", 32'(imem_req), 32'(mReqPending));
        checkVal("imem_addr", imem_addr, mAddr);
        checkVal("instr_valid", 32'(instr_valid), 32'(mHolding));
        checkVal("fetch_err", 32'(fetch_err), 32'(mErr));
        checkVal("err_code", 32'(err_code), 32'(mErrCode));
        if (mHolding) begin
            checkVal("instr", instr, mInstr);
            checkVal("instr_pc", instr_pc, mInstrPc);
        end
    endtask

    // Single compare process, sampling on the falling edge.
    always @(negedge clk) begin
        if (checkEn) checkOutput();
    end

    // Drives one cycle of inputs, steps the model and moves to just after the next falling edge.
    task automatic applyStimulus(input bit pv, input logic [31:0] pc, input bit fl,
                                 input bit gt, input bit rv, input logic [31:0] rd,
                                 input bit rdy);
        pc_valid    = pv;
        pc_in       = pc;
        flush       = fl;
        imem_gnt    = gt;
        imem_rvalid = rv;
        imem_rdata  = rd;
        instr_ready = rdy;
        modelStep(pv, pc, fl, gt, rv, rd, rdy);
        @(negedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    function automatic int pickLatency();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 7) return $urandom_range(1, 4);
        if (sel == 7) return MAX_WAIT;
        if (sel == 8) return MAX_WAIT + 5;
        return $urandom_range(5, MAX_WAIT - 1);
    endfunction

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios, then randomized traffic.
    initial begin
        modelReset();
        repeat (2) @(negedge clk);
        #1;
        reset_n = 1'b1;
        checkEn = 1'b1;
        checkVal("lit_reset_pc_ready", 32'(pc_ready), 32'h1);
        checkVal("lit_reset_imem_req", 32'(imem_req), 32'h0);
        checkVal("lit_reset_instr_valid", 32'(instr_valid), 32'h0);
        checkVal("lit_reset_err_code", 32'(err_code), 32'h0);
        checkVal("lit_reset_instr", instr, 32'h0);

        // Basic fetch
        applyStimulus(1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkVal("lit_t1_req", 32'(imem_req), 32'h1);
        checkVal("lit_t1_addr", imem_addr, 32'h0000_0040);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        checkVal("lit_t1_req_drop", 32'(imem_req), 32'h0);
        idleCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8C22_0004, 1'b0);
        checkVal("lit_t1_valid", 32'(instr_valid), 32'h1);
        checkVal("lit_t1_instr", instr, 32'h8C22_0004);
        checkVal("lit_t1_pc", instr_pc, 32'h0000_0040);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkVal("lit_t1_valid_off", 32'(instr_valid), 32'h0);
        checkVal("lit_t1_pc_ready", 32'(pc_ready), 32'h1);

        // Backpressure
        applyStimulus(1'b1, 32'h0000_0080, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h2108_FFFF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            checkVal("lit_t2_hold_instr", instr, 32'h2108_FFFF);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkVal("lit_t2_released", 32'(instr_valid), 32'h0);

        // Misaligned PC
        applyStimulus(1'b1, 32'h0000_0042, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkVal("lit_t3_err", 32'(fetch_err), 32'h1);
        checkVal("lit_t3_code", 32'(err_code), 32'h1);
        checkVal("lit_t3_no_req", 32'(imem_req), 32'h0);
        idleCycle();
        checkVal("lit_t3_pulse_end", 32'(fetch_err), 32'h0);

        // Timeout after MAX_WAIT waiting cycles
        applyStimulus(1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < MAX_WAIT - 1; i++) idleCycle();
        checkVal("lit_t4_still_waiting", 32'(pc_ready), 32'h0);
        checkVal("lit_t4_no_err_yet", 32'(fetch_err), 32'h0);
        idleCycle();
        checkVal("lit_t4_err", 32'(fetch_err), 32'h1);
        checkVal("lit_t4_code", 32'(err_code), 32'h2);
        checkVal("lit_t4_pc_ready", 32'(pc_ready), 32'h1);

        // Data on the last allowed waiting cycle wins over timeout
        applyStimulus(1'b1, 32'h0000_0104, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < MAX_WAIT - 1; i++) idleCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b0);
        checkVal("lit_edge_valid", 32'(instr_valid), 32'h1);
        checkVal("lit_edge_no_err", 32'(fetch_err), 32'h0);
        checkVal("lit_edge_instr", instr, 32'h1234_5678);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Flush while waiting for data
        applyStimulus(1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        idleCycle();
        idleCycle();
        checkVal("lit_t5_draining", 32'(pc_ready), 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        checkVal("lit_t5_no_valid", 32'(instr_valid), 32'h0);
        checkVal("lit_t5_pc_ready", 32'(pc_ready), 32'h1);

        // Asynchronous reset between edges while a request is outstanding
        applyStimulus(1'b1, 32'h0000_0300, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        pc_valid = 1'b0;
        pc_in = '0;
        #2;
        reset_n = 1'b0;
        #1;
        checkVal("lit_t6_req_off", 32'(imem_req), 32'h0);
        checkVal("lit_t6_valid_off", 32'(instr_valid), 32'h0);
        checkVal("lit_t6_addr", imem_addr, 32'h0);
        checkVal("lit_t6_code", 32'(err_code), 32'h0);
        checkEn = 1'b0;
        modelReset();
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        checkEn = 1'b1;
        applyStimulus(1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h2408_0001, 1'b0);
        checkVal("lit_t6_instr", instr, 32'h2408_0001);
        checkVal("lit_t6_pc", instr_pc, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            bit          pv, fl, gt, rv, rdy;
            logic [31:0] pc, rd;
            pv  = ($urandom_range(0, 9) < 6);
            pc  = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) pc[1:0] = 2'($urandom_range(1, 3));
            fl  = ($urandom_range(0, 19) == 0);
            rdy = 1'($urandom_range(0, 1));
            rd  = $urandom;
            gt  = 1'b0;
            rv  = 1'b0;
            if (mReqPending) begin
                gt = 1'($urandom_range(0, 1));
                rv = ($urandom_range(0, 29) == 0);
                if (gt) rvTarget = pickLatency();
            end else if (mWaitCount >= 0) begin
                rv = (mWaitCount + 1 == rvTarget);
            end
            applyStimulus(pv, pc, fl, gt, rv, rd, rdy);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction-fetch reader that consumes the program counter and turns it into one fetched instruction at a time.
- Latches a PC from the PC register (pc_in with pc_valid), issues a word read to instruction memory over a req/gnt + rvalid handshake, and presents the returned instruction to decode on a valid/ready interface.
- Sits between the PC register / next-PC logic and the decode stage of the multi-cycle Mini-MIPS core.
- Supports flush (branch/jump redirect) and detects misaligned PCs.

Parameters:
- ADDR_W, 32, width of PC and instruction-memory address.
- DATA_W, 32, instruction width.
- MAX_WAIT, 15, cycles allowed between grant and rvalid before a timeout error is raised.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pc_in  in  ADDR_W  fetch address from the PC register.
- pc_valid  in  1  pc_in is valid; accepted when pc_ready=1.
- pc_ready  out  1  unit is in IDLE and can accept a PC.
- flush  in  1  discard the current fetch and return to IDLE.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  ADDR_W  word-aligned read address.
- imem_gnt  in  1  memory accepted the request.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  DATA_W  read data.
- instr_valid  out  1  instr/instr_pc valid to decode.
- instr_ready  in  1  decode accepts the instruction.
- instr  out  DATA_W  fetched instruction.
- instr_pc  out  ADDR_W  PC of the fetched instruction.
- fetch_err  out  1  one-cycle pulse: misaligned PC or timeout.
- err_code  out  2  01 = misaligned, 10 = timeout; holds its value until the next error.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE; imem_req=0, imem_addr=0, instr_valid=0, instr=0, instr_pc=0, fetch_err=0, err_code=0, wait counter=0. pc_ready=1 once reset_n=1.
- States: IDLE, REQ, WAIT, HOLD.
- IDLE:
  - pc_ready=1.
  - On pc_valid with pc_in[1:0]==0: latch pc_in into addr_q, go to REQ.
  - On pc_valid with pc_in[1:0]!=0: fetch_err=1 for one cycle, err_code=01, stay in IDLE, no memory request.
- REQ:
  - imem_req=1, imem_addr=addr_q, both held stable until imem_gnt.
  - imem_gnt=1 → WAIT, counter cleared.
  - Request is never withdrawn without a grant, except by flush.
- WAIT:
  - imem_req=0; counter increments each cycle.
  - imem_rvalid=1 → capture imem_rdata into instr, addr_q into instr_pc, go to HOLD.
  - Counter reaching MAX_WAIT without rvalid → fetch_err pulse, err_code=10, go to IDLE.
  - rvalid in the same cycle the counter hits MAX_WAIT: data wins, no error.
  - Zero-latency memory (gnt and rvalid in the same cycle as the request) is not supported. rvalid is only sampled in WAIT; rvalid seen in REQ is ignored.
- HOLD:
  - instr_valid=1; instr and instr_pc stable while instr_ready=0.
  - instr_ready=1 → IDLE next cycle.
  - Minimum PC-to-instr_valid latency is 3 cycles (accept, grant, rvalid), giving a throughput of at most one instruction per 4 cycles.
- flush (highest priority over every other event):
  - REQ or HOLD: next state IDLE, instr_valid=0 next cycle.
  - WAIT: go to DRAIN-by-counter (same state encoding as WAIT with a drop flag set). The pending rvalid is consumed and discarded, then IDLE. A timeout while dropping returns to IDLE with no error.
  - flush and pc_valid in the same cycle in IDLE: the PC is ignored.
- Only one outstanding memory transaction at any time.
- pc_ready=1 only in IDLE with the drop flag clear.
- Reset asserted mid-transaction: immediate return to IDLE. Memory must tolerate an abandoned request.

Decomposition:
- Package ifetch_pkg:
  - state enum (IDLE, REQ, WAIT, HOLD).
  - err_code constants ERR_NONE=00, ERR_MISALIGN=01, ERR_TIMEOUT=10.
- Sub-module ifetch_wait_timer: counter with clear, enable, and a terminal flag at MAX_WAIT.
- FSM and output registers stay in ifetch_unit.

Test Plan:
1. Basic fetch: pc_in=0x0000_0040, pc_valid for 1 cycle; gnt on the next cycle; rvalid with rdata=0x8C220004 two cycles later; instr_ready=1 → instr=0x8C220004, instr_pc=0x40, instr_valid high 1 cycle, pc_ready back to 1.
2. Backpressure: as in test 1 but instr_ready=0 for 5 cycles → instr_valid stays 1 with instr/instr_pc constant; accepted on cycle 6.
3. Misaligned: pc_in=0x0000_0042 → fetch_err pulse, err_code=01, imem_req never asserted.
4. Timeout: gnt given, rvalid withheld for MAX_WAIT (15) cycles → fetch_err pulse, err_code=10, IDLE, pc_ready=1.
5. Flush in WAIT: flush 1 cycle after gnt, rvalid 3 cycles later (rdata=0xDEADBEEF) → instr_valid never asserts; pc_ready=0 until the drop completes, then 1.
6. Async reset: reset_n low mid-WAIT, between clock edges → imem_req=0 and instr_valid=0 immediately; after release a fetch of 0x0 completes normally.
